// File: rtl/alu_64.sv
// Y86-64 execute-stage ALU: add/sub/and/xor on 64-bit signed operands with
// registered result, signed-overflow and zero flags (one cycle of latency).
module alu_64 (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  opcode,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] res,
  output logic        overflow,
  output logic        zero
);

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpAnd = 2'b10,
    OpXor = 2'b11
  } aluOp_e;

  aluOp_e      opSel;
  logic        isSub;
  logic [63:0] bOperand;
  logic [63:0] sum;
  logic        sumOverflow;
  logic [63:0] res_d;
  logic        overflow_d;
  logic        zero_d;
  logic [63:0] res_q;
  logic        overflow_q;
  logic        zero_q;

  assign opSel = aluOp_e'(opcode);
  assign isSub = (opSel == OpSub);

  // Single shared adder: subtraction is a + ~b + 1, so B is inverted and the
  // carry-in is the subtract select. The carry-out is dropped.
  assign bOperand    = isSub ? ~b : b;
  assign sum         = a + bOperand + {63'd0, isSub};
  assign sumOverflow = (a[63] == bOperand[63]) && (sum[63] != a[63]);

  always_comb begin
    res_d      = '0;
    overflow_d = 1'b0;
    unique case (opSel)
      OpAdd, OpSub: begin
        res_d      = sum;
        overflow_d = sumOverflow;
      end
      OpAnd: res_d = a & b;
      OpXor: res_d = a ^ b;
      default: begin
        res_d      = '0;
        overflow_d = 1'b0;
      end
    endcase
    zero_d = (res_d == 64'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q      <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      res_q      <= res_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign res      = res_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_alu_64.sv
// Self-checking bench for alu_64: expected results are queued when operands
// are driven and popped once the registered outputs should reflect them.
module tb_alu_64;

  typedef struct packed {
    logic [63:0] res;
    logic        ov;
    logic        z;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  opcode;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] res;
  logic        overflow;
  logic        zero;

  exp_t sbq[$];
  int   vectorsApplied = 0;
  int   miscompares    = 0;

  alu_64 dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .a        (a),
    .b        (b),
    .res      (res),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model using 65-bit signed arithmetic for overflow detection.
  function automatic exp_t model(input logic [1:0] op, input logic [63:0] x, input logic [63:0] y);
    exp_t        e;
    logic [64:0] wide;
    e.ov = 1'b0;
    case (op)
      2'b00: begin
        wide  = {x[63], x} + {y[63], y};
        e.res = wide[63:0];
        e.ov  = wide[64] ^ wide[63];
      end
      2'b01: begin
        wide  = {x[63], x} - {y[63], y};
        e.res = wide[63:0];
        e.ov  = wide[64] ^ wide[63];
      end
      2'b10: e.res = x & y;
      default: e.res = x ^ y;
    endcase
    e.z = (e.res == 64'd0);
    return e;
  endfunction

  task automatic driveOp(input logic [1:0] op, input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    opcode = op;
    a      = x;
    b      = y;
    sbq.push_back(model(op, x, y));
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    opcode = 2'b11; a = 64'd11; b = 64'd42;
    repeat (2) @(posedge clk);
    #1;
    vectorsApplied++;
    if (res !== 64'd0 || overflow !== 1'b0 || zero !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: got res=%h ov=%b z=%b, need res=0 ov=0 z=1", res, overflow, zero);
    end
    @(negedge clk);
    rst = 1'b0;
    driveOp(2'b11, 64'd11, 64'd42);
    @(posedge clk); #1;
    e = sbq.pop_front();
    vectorsApplied++;
    if (res !== e.res || overflow !== e.ov || zero !== e.z) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got res=%h ov=%b z=%b, need res=%h ov=%b z=%b", res, overflow, zero, e.res, e.ov, e.z);
    end
    #2;
    rst = 1'b1;
    #1;
    vectorsApplied++;
    if (res !== 64'd0 || overflow !== 1'b0 || zero !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got res=%h ov=%b z=%b, need res=0 ov=0 z=1", res, overflow, zero);
    end
    @(posedge clk); #1;
    vectorsApplied++;
    if (res !== 64'd0 || overflow !== 1'b0 || zero !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_through_edge: got res=%h ov=%b z=%b, need res=0 ov=0 z=1", res, overflow, zero);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_xor();
    exp_t e;
    driveOp(2'b11, 64'd11, 64'd42);
    @(posedge clk); #1;
    e = sbq.pop_front();
    vectorsApplied++;
    if (res !== 64'd33 || e.res !== 64'd33 || overflow !== 1'b0 || zero !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL xor_directed: got res=%h ov=%b z=%b, need res=21 ov=0 z=0", res, overflow, zero);
    end
    for (int i = 0; i < 100; i++) begin
      driveOp(2'b11, rand64(), rand64());
      @(posedge clk); #1;
      e = sbq.pop_front();
      vectorsApplied++;
      if (res !== e.res || overflow !== e.ov || zero !== e.z) begin
        miscompares++;
        $display("[TB] FAIL xor_random[%0d]: got res=%h ov=%b z=%b, need res=%h ov=%b z=%b", i, res, overflow, zero, e.res, e.ov, e.z);
      end
    end
  endtask

  // Directed corner vectors for add, sub and and, with hand-derived results.
  task automatic test_arith();
    logic [1:0]  ops  [8];
    logic [63:0] as   [8];
    logic [63:0] bs   [8];
    logic [63:0] rExp [8];
    logic        oExp [8];
    logic        zExp [8];
    exp_t e;
    ops[0]=2'b00; as[0]=64'h7FFF_FFFF_FFFF_FFFF; bs[0]=64'd1; rExp[0]=64'h8000_0000_0000_0000; oExp[0]=1; zExp[0]=0;
    ops[1]=2'b00; as[1]=64'hFFFF_FFFF_FFFF_FFFF; bs[1]=64'd1; rExp[1]=64'd0;                  oExp[1]=0; zExp[1]=1;
    ops[2]=2'b01; as[2]=64'd5;                  bs[2]=64'd5; rExp[2]=64'd0;                  oExp[2]=0; zExp[2]=1;
    ops[3]=2'b01; as[3]=64'h8000_0000_0000_0000; bs[3]=64'd1; rExp[3]=64'h7FFF_FFFF_FFFF_FFFF; oExp[3]=1; zExp[3]=0;
    ops[4]=2'b10; as[4]=64'hF0F0;               bs[4]=64'hFF00; rExp[4]=64'hF000;            oExp[4]=0; zExp[4]=0;
    ops[5]=2'b10; as[5]=64'hAAAA_AAAA_AAAA_AAAA; bs[5]=64'h5555_5555_5555_5555; rExp[5]=64'd0; oExp[5]=0; zExp[5]=1;
    ops[6]=2'b00; as[6]=64'h8000_0000_0000_0000; bs[6]=64'h8000_0000_0000_0000; rExp[6]=64'd0; oExp[6]=1; zExp[6]=1;
    ops[7]=2'b01; as[7]=64'd3;                  bs[7]=64'd10; rExp[7]=64'hFFFF_FFFF_FFFF_FFF9; oExp[7]=0; zExp[7]=0;
    for (int i = 0; i < 8; i++) begin
      driveOp(ops[i], as[i], bs[i]);
      @(posedge clk); #1;
      e = sbq.pop_front();
      vectorsApplied++;
      if (res !== rExp[i] || overflow !== oExp[i] || zero !== zExp[i] || e.res !== rExp[i]) begin
        miscompares++;
        $display("[TB] FAIL arith[%0d] op=%b: got res=%h ov=%b z=%b, need res=%h ov=%b z=%b", i, ops[i], res, overflow, zero, rExp[i], oExp[i], zExp[i]);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    driveOp(2'b00, 64'd100, 64'd23);
    @(posedge clk); #3;
    a = 64'd999; b = 64'd1; opcode = 2'b01;
    #1;
    e = sbq.pop_front();
    vectorsApplied++;
    if (res !== e.res || overflow !== e.ov || zero !== e.z) begin
      miscompares++;
      $display("[TB] FAIL hold_between_edges: got res=%h ov=%b z=%b, need res=%h ov=%b z=%b", res, overflow, zero, e.res, e.ov, e.z);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      driveOp(2'($urandom_range(0, 3)), rand64(), (i % 5 == 0) ? 64'd0 : rand64());
      if (i == 20) begin
        #2;
        rst = 1'b1;
        #1;
        sbq.delete();
        vectorsApplied++;
        if (res !== 64'd0 || overflow !== 1'b0 || zero !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL b2b_midstream_reset: got res=%h ov=%b z=%b, need res=0 ov=0 z=1", res, overflow, zero);
        end
        @(posedge clk); #1;
        vectorsApplied++;
        if (res !== 64'd0 || overflow !== 1'b0 || zero !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL b2b_reset_edge: got res=%h ov=%b z=%b, need res=0 ov=0 z=1", res, overflow, zero);
        end
        @(negedge clk);
        rst = 1'b0;
      end else begin
        @(posedge clk); #1;
        vectorsApplied++;
        if (sbq.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL b2b[%0d]: scoreboard empty, got res=%h", i, res);
        end else begin
          e = sbq.pop_front();
          if (res !== e.res || overflow !== e.ov || zero !== e.z) begin
            miscompares++;
            $display("[TB] FAIL b2b[%0d]: got res=%h ov=%b z=%b, need res=%h ov=%b z=%b", i, res, overflow, zero, e.res, e.ov, e.z);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    opcode = 2'b00;
    a = '0;
    b = '0;
    test_reset();
    test_xor();
    test_arith();
    test_hold();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
